// File: rtl/serial_frame_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_frame_rx_pkg                                          |
// | Description : Shared frame levels, receiver state encodings, vote helper.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package serial_frame_rx_pkg;

    localparam int       c_DATA_BITS = 8;
    localparam logic     c_START_LVL = 1'b0;
    localparam logic     c_STOP_LVL  = 1'b1;
    localparam logic     c_IDLE_LVL  = 1'b1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_frame_rx_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_2ff                                                     |
// | Description : Two-flop synchronizer with parameterized reset value.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_frame_rx                                              |
// | Description : Oversampled, majority-voted serial byte receiver with        |
// |               valid/ready output, framing-error and overrun flags.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = c_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sr_clk,
    input  logic                 enable,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_SW = $clog2(OVERSAMPLE);
    localparam int c_BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_SW-1:0] c_S_ONE  = c_SW'(1);
    localparam logic [c_SW-1:0] c_S_LO   = c_SW'(OVERSAMPLE/2 - 1);
    localparam logic [c_SW-1:0] c_S_MID  = c_SW'(OVERSAMPLE/2);
    localparam logic [c_SW-1:0] c_S_HI   = c_SW'(OVERSAMPLE/2 + 1);
    localparam logic [c_SW-1:0] c_S_LAST = c_SW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_B_LAST = c_BW'(DATA_BITS - 1);

    logic                 w_line;
    logic                 w_vote;
    logic [2:0]           r_state;
    logic [c_SW-1:0]      r_s;
    logic [c_BW-1:0]      r_b;
    logic                 r_v0;
    logic                 r_v1;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    sync_2ff #(
        .RESET_VAL (c_IDLE_LVL)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (serial_in),
        .o_q (w_line)
    );

    // The third sample is the live line, so the vote resolves on the s=OS/2+1 strobe.
    assign w_vote = maj3(r_v0, r_v1, w_line);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_s          <= '0;
            r_b          <= '0;
            r_v0         <= 1'b1;
            r_v1         <= 1'b1;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end

            if (!enable) begin
                r_state <= c_ST_IDLE;
                r_s     <= '0;
                r_b     <= '0;
            end else if (sr_clk) begin
                if (r_s == c_S_LO) begin
                    r_v0 <= w_line;
                end
                if (r_s == c_S_MID) begin
                    r_v1 <= w_line;
                end

                case (r_state)
                    c_ST_IDLE: begin
                        if (w_line == c_START_LVL) begin
                            r_state <= c_ST_START;
                            r_s     <= c_S_ONE;
                        end
                    end
                    c_ST_START: begin
                        if (r_s == c_S_HI && w_vote != c_START_LVL) begin
                            r_state <= c_ST_IDLE;
                            r_s     <= '0;
                        end else if (r_s == c_S_LAST) begin
                            r_state <= c_ST_DATA;
                            r_s     <= '0;
                            r_b     <= '0;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                    c_ST_DATA: begin
                        if (r_s == c_S_HI) begin
                            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        end
                        if (r_s == c_S_LAST) begin
                            r_s <= '0;
                            if (r_b == c_B_LAST) begin
                                r_state <= c_ST_STOP;
                            end else begin
                                r_b <= r_b + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                    c_ST_STOP: begin
                        if (r_s == c_S_HI) begin
                            r_s <= '0;
                            if (w_vote == c_STOP_LVL) begin
                                r_state <= c_ST_IDLE;
                                if (!r_data_valid || data_ready) begin
                                    r_data_out   <= r_shift;
                                    r_data_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_state     <= c_ST_BREAK;
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                    c_ST_BREAK: begin
                        if (w_line == c_IDLE_LVL) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_s     <= '0;
                    end
                endcase
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
